ic_pfe: RTL

Next-line instruction prefetch engine for one core. It sits directly upstream of the instruction TLB. It watches PC requests the core sends to the TLB and trains a sequential-stream confidence counter. Once trained, it issues next-line prefetch requests on the TLB's opportunistic prefetch port using the standard valid/retry handshake.

---
 rtl/ic_pfe_if.sv | 36 +++
 rtl/ic_pfe.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ic_pfe_if.sv
// rtl/ic_pfe_if.sv - payload types and core/TLB handshake interface for ic_pfe
package ic_pfe_pkg;
  localparam int LADDR_W = 39;

  typedef struct packed {
    logic [LADDR_W-1:0] laddr;
    logic [3:0]         asid;
  } I_coretoictlb_pc_type;

  typedef struct packed {
    logic [LADDR_W-1:0] laddr;
    logic               l2;
    logic [3:0]         asid;
  } I_pfetol1tlb_req_type;
endpackage

interface ic_pfe_if;
  import ic_pfe_pkg::*;

  logic                 coretoictlb_pc_valid;
  logic                 coretoictlb_pc_retry;
  I_coretoictlb_pc_type coretoictlb_pc;
  logic                 pfetol1tlb_req_valid;
  logic                 pfetol1tlb_req_retry;
  I_pfetol1tlb_req_type pfetol1tlb_req;

  modport master (
    input  coretoictlb_pc_valid, coretoictlb_pc_retry, coretoictlb_pc, pfetol1tlb_req_retry,
    output pfetol1tlb_req_valid, pfetol1tlb_req
  );

  modport slave (
    output coretoictlb_pc_valid, coretoictlb_pc_retry, coretoictlb_pc, pfetol1tlb_req_retry,
    input  pfetol1tlb_req_valid, pfetol1tlb_req
  );
endinterface

// File: rtl/ic_pfe.sv
// rtl/ic_pfe.sv - next-line instruction prefetch engine; IC_PFE_L2_EN enables L2-distance prefetches
module ic_pfe
  import ic_pfe_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int L1_DIST = 2,
  parameter int THRESH  = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      pfe_flush,
  ic_pfe_if.master  bus
);
  localparam int LW = LADDR_W - 6;
`ifdef IC_PFE_L2_EN
  localparam int DEPTH_EFF = DEPTH;
`else
  localparam int DEPTH_EFF = (DEPTH < L1_DIST) ? DEPTH : L1_DIST;
`endif

  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nx;

  logic [LW-1:0] last_line, last_line_nx;
  logic          last_vld, last_vld_nx;
  logic [1:0]    conf, conf_nx;
  logic [LW-1:0] next_pf, next_pf_nx;
  logic [LW-1:0] end_pf, end_pf_nx;
  logic          out_valid, out_valid_nx;
  I_pfetol1tlb_req_type out_req, out_req_nx;

  logic [LW-1:0] line, line_p1, pf_inc, pf_base, new_next, end_new;
  logic [1:0]    conf_up;
  logic          acc, same, seq, trig, abort, load;
  logic          unused_pc;

  assign unused_pc = ^{bus.coretoictlb_pc.asid, bus.coretoictlb_pc.laddr[5:0]};

  assign line    = bus.coretoictlb_pc.laddr[LADDR_W-1:6];
  assign line_p1 = line + LW'(1);
  assign acc     = bus.coretoictlb_pc_valid & ~bus.coretoictlb_pc_retry & ~pfe_flush;
  assign same    = last_vld && (line == last_line);
  assign seq     = last_vld && (line == last_line + LW'(1));
  assign conf_up = (conf == 2'd3) ? 2'd3 : conf + 2'd1;
  assign trig    = acc && seq && (conf_up >= 2'(THRESH));
  assign abort   = pfe_flush || (acc && last_vld && !same && !seq);
  assign load    = (state == ISSUE) && !abort && (!out_valid || !bus.pfetol1tlb_req_retry);
  assign pf_inc  = next_pf + LW'(1);
  // A retrigger mid-stream never rewinds: lines already issued stay issued.
  assign pf_base  = load ? pf_inc : next_pf;
  assign new_next = ((state == ISSUE) && (pf_base > line_p1)) ? pf_base : line_p1;
  assign end_new  = line + LW'(DEPTH_EFF);

  always_comb begin
    state_nx     = state;
    last_line_nx = last_line;
    last_vld_nx  = last_vld;
    conf_nx      = conf;
    next_pf_nx   = next_pf;
    end_pf_nx    = end_pf;
    out_valid_nx = out_valid;
    out_req_nx   = out_req;

    if (out_valid && !bus.pfetol1tlb_req_retry)
      out_valid_nx = 1'b0;

    if (load) begin
      out_valid_nx     = 1'b1;
      out_req_nx       = '0;
      out_req_nx.laddr = {next_pf, 6'b0};
`ifdef IC_PFE_L2_EN
      out_req_nx.l2    = (next_pf - last_line) > LW'(L1_DIST);
`endif
      next_pf_nx = pf_inc;
      // Low six line bits wrapping to zero means the next line is in another 4 KB page.
      if ((pf_inc > end_pf) || (pf_inc[5:0] == 6'd0))
        state_nx = IDLE;
    end

    if (pfe_flush) begin
      last_vld_nx = 1'b0;
      conf_nx     = 2'd0;
      state_nx    = IDLE;
    end else if (acc) begin
      if (!last_vld) begin
        last_line_nx = line;
        last_vld_nx  = 1'b1;
        conf_nx      = 2'd0;
      end else if (seq) begin
        conf_nx      = conf_up;
        last_line_nx = line;
        if (trig) begin
          next_pf_nx = new_next;
          end_pf_nx  = end_new;
          state_nx   = ((new_next[LW-1:6] == line[LW-1:6]) && (new_next <= end_new)) ? ISSUE : IDLE;
        end
      end else if (!same) begin
        conf_nx      = 2'd0;
        last_line_nx = line;
        state_nx     = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_line <= '0;
      last_vld  <= 1'b0;
      conf      <= 2'd0;
      next_pf   <= '0;
      end_pf    <= '0;
      out_valid <= 1'b0;
      out_req   <= '0;
    end else begin
      state     <= state_nx;
      last_line <= last_line_nx;
      last_vld  <= last_vld_nx;
      conf      <= conf_nx;
      next_pf   <= next_pf_nx;
      end_pf    <= end_pf_nx;
      out_valid <= out_valid_nx;
      out_req   <= out_req_nx;
    end
  end

  assign bus.pfetol1tlb_req_valid = out_valid;
  assign bus.pfetol1tlb_req       = out_req;
endmodule
